video_in_store: RTL and testbench
=================================

Name: video_in_store

Overview:
Downstream neighbour of the video-in capture stage. Drains the 32-bit packed-pixel FIFO (4 pixels/word) and writes each frame into system memory as a Wishbone master, in fixed-length bursts. Double-buffered: frames alternate between two base addresses, and a one-cycle pulse marks each completed frame for the display/processing side.

Parameters:
BURST_LEN, 8, words per Wishbone burst; FRAME_WORDS must be an exact multiple of it
FRAME_WORDS, 76800, 32-bit words per frame (640*480/4)
LEVEL_W, 6, width of fifo_level (FIFO depth 32)
CNT_W, 17, width of the frame word counter; must satisfy 2**CNT_W > FRAME_WORDS

Ports:
clk  in  1  system clock (100 MHz domain)
nRST  in  1  asynchronous active-low reset
enable  in  1  store enable; sampled only in IDLE
buf0_addr  in  32  byte base address of buffer 0, word aligned
buf1_addr  in  32  byte base address of buffer 1, word aligned
fifo_data  in  32  FIFO head word, first-word-fall-through, valid when fifo_empty=0
fifo_level  in  LEVEL_W  words currently in FIFO
fifo_empty  in  1  FIFO empty flag
fifo_r_e  out  1  pop strobe, one word per asserted cycle
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable; always 1 while wb_cyc_o=1
wb_sel_o  out  4  byte select; 4'hF while wb_stb_o=1, else 0
wb_adr_o  out  32  byte address
wb_dat_o  out  32  write data
wb_ack_i  in  1  slave acknowledge
buf_sel  out  1  buffer currently being written
frame_done  out  1  one-cycle pulse when the last word of a frame is acknowledged

Behaviour:
- Reset (async, nRST=0): state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, fifo_r_e, frame_done = 0; wb_sel_o = 0; wb_adr_o = 0; word_cnt = 0; beat_cnt = 0; buf_sel = 0. Reset mid-burst drops the cycle immediately. Words already popped are lost; the FIFO is not flushed.
- FSM states: IDLE, BURST.
- IDLE -> BURST when enable=1 and fifo_level >= BURST_LEN. On the transition edge: wb_cyc_o, wb_stb_o, wb_we_o = 1; wb_sel_o = 4'hF; wb_adr_o = base(buf_sel) + 4*word_cnt; beat_cnt = 0.
- While in IDLE, a word_cnt of 0 selects the new frame's base, sampled at that edge.
- BURST: wb_cyc_o and wb_stb_o are held high across beats. wb_dat_o = fifo_data combinationally while wb_stb_o = 1, else 0.
- On a cycle with wb_ack_i = 1:
  - fifo_r_e = 1 combinationally in that cycle.
  - word_cnt and beat_cnt increment.
  - wb_adr_o advances by 4 at that edge.
- Burst end: an ack with beat_cnt = BURST_LEN-1 -> IDLE. wb_cyc_o and wb_stb_o drop at that edge, so they are low the next cycle. There is a minimum of one idle cycle between bursts.
- Frame end: an ack with word_cnt = FRAME_WORDS-1:
  - word_cnt wraps to 0 and buf_sel toggles at that edge.
  - frame_done = 1 for exactly the following cycle.
  - Because FRAME_WORDS is a multiple of BURST_LEN, this always coincides with a burst end.
- enable deasserted mid-burst: the burst completes. The FSM stays in IDLE afterwards; word_cnt and buf_sel are kept, so capture resumes at the same offset.
- Wait states: wb_ack_i may be low for any number of cycles. Address, data and strobe hold stable and no pop occurs.
- An ack outside BURST is ignored.
- fifo_empty is never expected low-to-high inside a burst, because of the level check.
- Simulation only: pop while fifo_empty=1 -> $display error and $stop, guarded by translate_off/on.
- Base addresses are sampled only at frame start. Software reprograms only the buffer with index !buf_sel.

Optional Feature:
VIDEO_IN_STORE_ERR_EN:
- Defined: adds input wb_err_i (1 bit) and output wb_error (1 bit, sticky, reset 0).
- wb_err_i=1 in BURST ends the cycle at that edge without popping. wb_error is then set.
- The FSM stays in IDLE until nRST, ignoring enable.
- Undefined: neither port exists, and the FSM matches the base behaviour above.

Test Plan:
1. Reset, enable=1, fifo_level=8, ack every cycle -> cyc high 8 cycles; addresses buf0+0..buf0+28; 8 pops; data equals FIFO words in order; cyc low on cycle 9.
2. fifo_level=7 with enable=1 -> no cycle starts. Level rises to 8 -> cyc asserts next edge with wb_adr_o=buf0_addr.
3. Ack low for 3 cycles between beats 2 and 3 -> wb_adr_o and wb_dat_o stable; fifo_r_e=0 during the wait; total pops still 8.
4. FRAME_WORDS=16 override, BURST_LEN=8, buf0=0x1000, buf1=0x8000:
   - Two bursts -> frame_done pulses once; buf_sel=1.
   - Next burst starts at 0x8000. After 16 more words, buf_sel=0 and the next frame starts at 0x1000.
5. enable dropped at beat 4 -> burst finishes all 8 beats, then no new cycle. Re-enable -> next address continues at offset 32.
6. nRST pulsed low mid-burst -> wb_cyc_o=0 immediately; after release, the first burst restarts at buf0_addr with buf_sel=0 (with ERR_EN: wb_err_i at beat 2 -> wb_error=1, no further cycles).

Source files
------------

// File: rtl/video_in_store_if.sv
// Wishbone write-master bundle between video_in_store and system memory.
// Defining VIDEO_IN_STORE_ERR_EN adds the slave error return wb_err_i.
interface video_in_store_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;
`ifdef VIDEO_IN_STORE_ERR_EN
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_ack_i, wb_err_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_ack_i, wb_err_i
  );
`else
  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_ack_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_ack_i
  );
`endif
endinterface

// File: rtl/video_in_store.sv
// Drains the packed-pixel FIFO into double-buffered frame memory via Wishbone bursts.
// Optional macro VIDEO_IN_STORE_ERR_EN: wb_err_i aborts a burst and latches sticky wb_error.
module video_in_store #(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 76800,
  parameter int LEVEL_W     = 6,
  parameter int CNT_W       = 17
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               enable,
  input  logic [31:0]        buf0_addr,
  input  logic [31:0]        buf1_addr,
  input  logic [31:0]        fifo_data,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_empty,
  output logic               fifo_r_e,
  video_in_store_if.master   wb,
  output logic               buf_sel,
`ifdef VIDEO_IN_STORE_ERR_EN
  output logic               wb_error,
`endif
  output logic               frame_done
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_adr;
  logic [31:0]        r_base;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic               r_buf_sel;
  logic               r_frame_done;
  logic               r_error;

  logic               w_in_burst;
  logic               w_err;
  logic               w_beat;
  logic               w_start;
  logic               w_last_beat;
  logic               w_last_word;
  logic [31:0]        w_new_base;
  logic [31:0]        w_offset;

  assign w_in_burst = (r_state == S_BURST);
`ifdef VIDEO_IN_STORE_ERR_EN
  assign w_err      = w_in_burst && wb.wb_err_i;
`else
  assign w_err      = 1'b0;
`endif
  // An error beat is never counted or popped, even if the slave also acks.
  assign w_beat      = w_in_burst && wb.wb_ack_i && !w_err;
  assign w_start     = (r_state == S_IDLE) && enable && !r_error &&
                       (fifo_level >= LEVEL_W'(BURST_LEN));
  assign w_last_beat = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign w_last_word = (r_word_cnt == CNT_W'(FRAME_WORDS - 1));
  assign w_new_base  = r_buf_sel ? buf1_addr : buf0_addr;
  assign w_offset    = 32'({r_word_cnt, 2'b00});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_BURST;
      S_BURST: if (w_err || (w_beat && w_last_beat)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wb.wb_cyc_o = w_in_burst;
    wb.wb_stb_o = w_in_burst;
    wb.wb_we_o  = w_in_burst;
    wb.wb_sel_o = w_in_burst ? 4'hF : 4'h0;
    wb.wb_dat_o = w_in_burst ? fifo_data : 32'h0;
    wb.wb_adr_o = r_adr;
    fifo_r_e    = w_beat;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_adr        <= 32'h0;
      r_base       <= 32'h0;
      r_word_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_buf_sel    <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_err) r_error <= 1'b1;
      if (w_start) begin
        r_beat_cnt <= '0;
        // A frame's base is latched once, at its first burst; later bursts reuse it.
        if (r_word_cnt == '0) begin
          r_base <= w_new_base;
          r_adr  <= w_new_base;
        end else begin
          r_adr  <= r_base + w_offset;
        end
      end else if (w_beat) begin
        r_adr      <= r_adr + 32'd4;
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        if (w_last_word) begin
          r_word_cnt   <= '0;
          r_buf_sel    <= ~r_buf_sel;
          r_frame_done <= 1'b1;
        end else begin
          r_word_cnt   <= r_word_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign buf_sel    = r_buf_sel;
  assign frame_done = r_frame_done;
`ifdef VIDEO_IN_STORE_ERR_EN
  assign wb_error   = r_error;
`endif

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!nRST)
    !(fifo_r_e && fifo_empty));

endmodule

// File: tb/tb_video_in_store.sv
// Randomized self-checking bench for video_in_store: FIFO queue model plus frame/offset address model.
module tb_video_in_store;
  localparam int BL = 8;
  localparam int FW = 16;
  localparam logic [31:0] BUF0 = 32'h0000_1000;
  localparam logic [31:0] BUF1 = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        nRST;
  logic        enable;
  logic [31:0] buf0_addr, buf1_addr, fifo_data;
  logic [5:0]  fifo_level;
  logic        fifo_empty, fifo_r_e, buf_sel, frame_done;
`ifdef VIDEO_IN_STORE_ERR_EN
  logic        wb_error;
`endif

  video_in_store_if wb ();

  video_in_store #(.BURST_LEN(BL), .FRAME_WORDS(FW), .LEVEL_W(6), .CNT_W(17)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .enable     (enable),
    .buf0_addr  (buf0_addr),
    .buf1_addr  (buf1_addr),
    .fifo_data  (fifo_data),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .fifo_r_e   (fifo_r_e),
    .wb         (wb),
    .buf_sel    (buf_sel),
`ifdef VIDEO_IN_STORE_ERR_EN
    .wb_error   (wb_error),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q[$];
  int          m_off;
  logic        m_buf;

  function automatic logic [31:0] exp_addr();
    return (m_buf ? BUF1 : BUF0) + 32'(m_off * 4);
  endfunction

  task automatic drive_fifo();
    fifo_level = (q.size() > 63) ? 6'd63 : 6'(q.size());
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic push_words(input int n);
    repeat (n) q.push_back($urandom);
    drive_fifo();
  endtask

  // Advance to just after the next falling edge, retiring a pop the DUT took at the rising edge.
  task automatic next_cycle(input bit pop);
    @(negedge clk);
    if (pop) void'(q.pop_front());
    drive_fifo();
    #1;
  endtask

  // Starts at an idle cycle whose inputs allow a burst; ends on the idle cycle after it.
  task automatic do_burst(input int wait_beat, input int wait_len, input int drop_en_beat,
                          input bit rand_waits);
    logic [31:0] a;
    int nwait;
    int pops = 0;
    bit frame_end = 0;
    next_cycle(0);
    for (int b = 0; b < BL; b++) begin
      a = exp_addr();
      nwait = (b == wait_beat) ? wait_len : (rand_waits ? int'($urandom_range(0, 2)) : 0);
      for (int w = 0; w < nwait; w++) begin
        wb.wb_ack_i = 1'b0;
        #1;
        checks++; if (wb.wb_cyc_o !== 1'b1 || wb.wb_stb_o !== 1'b1) begin failures++;
          $display("FAIL wait_cyc_stb act=%b%b exp=11", wb.wb_cyc_o, wb.wb_stb_o); end
        checks++; if (wb.wb_adr_o !== a) begin failures++;
          $display("FAIL wait_adr act=%h exp=%h", wb.wb_adr_o, a); end
        checks++; if (wb.wb_dat_o !== q[0]) begin failures++;
          $display("FAIL wait_dat act=%h exp=%h", wb.wb_dat_o, q[0]); end
        checks++; if (fifo_r_e !== 1'b0) begin failures++;
          $display("FAIL wait_pop act=%b exp=0", fifo_r_e); end
        if (fifo_r_e === 1'b1) pops++;
        next_cycle(0);
      end
      wb.wb_ack_i = 1'b1;
      if (b == drop_en_beat) enable = 1'b0;
      #1;
      checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o} !== 3'b111) begin failures++;
        $display("FAIL beat_ctl act=%b%b%b exp=111", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o); end
      checks++; if (wb.wb_sel_o !== 4'hF) begin failures++;
        $display("FAIL beat_sel act=%h exp=f", wb.wb_sel_o); end
      checks++; if (wb.wb_adr_o !== a) begin failures++;
        $display("FAIL beat_adr beat=%0d act=%h exp=%h", b, wb.wb_adr_o, a); end
      checks++; if (wb.wb_dat_o !== q[0]) begin failures++;
        $display("FAIL beat_dat beat=%0d act=%h exp=%h", b, wb.wb_dat_o, q[0]); end
      checks++; if (fifo_r_e !== 1'b1) begin failures++;
        $display("FAIL beat_pop act=%b exp=1", fifo_r_e); end
      checks++; if (frame_done !== 1'b0) begin failures++;
        $display("FAIL beat_frame_done act=%b exp=0", frame_done); end
      if (fifo_r_e === 1'b1) pops++;
      m_off++;
      if (m_off == FW) begin m_off = 0; m_buf = ~m_buf; frame_end = 1; end
      next_cycle(1);
    end
    wb.wb_ack_i = 1'b0;
    #1;
    checks++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0) begin failures++;
      $display("FAIL end_cyc_stb act=%b%b exp=00", wb.wb_cyc_o, wb.wb_stb_o); end
    checks++; if (wb.wb_sel_o !== 4'h0 || wb.wb_dat_o !== 32'h0) begin failures++;
      $display("FAIL end_sel_dat act=%h/%h exp=0/0", wb.wb_sel_o, wb.wb_dat_o); end
    checks++; if (frame_done !== frame_end) begin failures++;
      $display("FAIL end_frame_done act=%b exp=%b", frame_done, frame_end); end
    checks++; if (buf_sel !== m_buf) begin failures++;
      $display("FAIL end_buf_sel act=%b exp=%b", buf_sel, m_buf); end
    checks++; if (pops != BL) begin failures++;
      $display("FAIL burst_pops act=%0d exp=%0d", pops, BL); end
  endtask

  task automatic expect_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      next_cycle(0);
      checks++; if (wb.wb_cyc_o !== 1'b0 || fifo_r_e !== 1'b0) begin failures++;
        $display("FAIL %s_idle act=%b%b exp=00", tag, wb.wb_cyc_o, fifo_r_e); end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, fifo_r_e, frame_done, buf_sel} !== 6'b0)
      begin failures++; $display("FAIL reset_ctl act=%b%b%b%b%b%b exp=000000", wb.wb_cyc_o,
        wb.wb_stb_o, wb.wb_we_o, fifo_r_e, frame_done, buf_sel); end
    checks++; if (wb.wb_sel_o !== 4'h0 || wb.wb_adr_o !== 32'h0) begin failures++;
      $display("FAIL reset_sel_adr act=%h/%h exp=0/0", wb.wb_sel_o, wb.wb_adr_o); end
    next_cycle(0);
    nRST = 1'b1;
    m_off = 0;
    m_buf = 1'b0;
  endtask

  task automatic test_single_burst();
    enable = 1'b1;
    push_words(BL);
    do_burst(-1, 0, -1, 0);
    expect_idle(3, "empty");
  endtask

  task automatic test_level_threshold();
    push_words(BL - 1);
    expect_idle(4, "level7");
    push_words(1);
    do_burst(-1, 0, -1, 0);
  endtask

  task automatic test_wait_states();
    push_words(BL);
    do_burst(3, 3, -1, 0);
  endtask

  task automatic test_frame_wrap();
    push_words(2 * BL);
    do_burst(-1, 0, -1, 1);
    do_burst(-1, 0, -1, 1);
    push_words(2 * BL);
    do_burst(-1, 0, -1, 1);
    do_burst(-1, 0, -1, 1);
  endtask

  task automatic test_enable_drop();
    push_words(2 * BL);
    do_burst(-1, 0, 4, 0);
    expect_idle(5, "disabled");
    enable = 1'b1;
    do_burst(-1, 0, -1, 0);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a;
    push_words(BL);
    next_cycle(0);
    for (int b = 0; b < 3; b++) begin
      a = exp_addr();
      wb.wb_ack_i = 1'b1;
      #1;
      checks++; if (wb.wb_adr_o !== a || fifo_r_e !== 1'b1) begin failures++;
        $display("FAIL pre_reset_beat act=%h/%b exp=%h/1", wb.wb_adr_o, fifo_r_e, a); end
      m_off++;
      next_cycle(1);
    end
    wb.wb_ack_i = 1'b0;
    nRST = 1'b0;
    #1;
    checks++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || fifo_r_e !== 1'b0) begin
      failures++; $display("FAIL reset_drop act=%b%b%b exp=000", wb.wb_cyc_o, wb.wb_stb_o,
        fifo_r_e); end
    checks++; if (buf_sel !== 1'b0 || wb.wb_adr_o !== 32'h0) begin failures++;
      $display("FAIL reset_drop_state act=%b/%h exp=0/0", buf_sel, wb.wb_adr_o); end
    next_cycle(0);
    nRST = 1'b1;
    m_off = 0;
    m_buf = 1'b0;
    push_words(3);
    do_burst(-1, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      if (q.size() < BL) push_words(BL - q.size() + int'($urandom_range(0, BL)));
      do_burst(-1, 0, -1, 1);
    end
  endtask

`ifdef VIDEO_IN_STORE_ERR_EN
  task automatic test_error();
    push_words(BL);
    next_cycle(0);
    for (int b = 0; b < 2; b++) begin
      wb.wb_ack_i = 1'b1;
      #1;
      m_off++;
      next_cycle(1);
    end
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b1;
    #1;
    checks++; if (fifo_r_e !== 1'b0) begin failures++;
      $display("FAIL err_pop act=%b exp=0", fifo_r_e); end
    next_cycle(0);
    wb.wb_err_i = 1'b0;
    checks++; if (wb.wb_cyc_o !== 1'b0 || wb_error !== 1'b1) begin failures++;
      $display("FAIL err_abort act=%b/%b exp=0/1", wb.wb_cyc_o, wb_error); end
    push_words(BL);
    expect_idle(6, "err_locked");
  endtask
`endif

  initial begin
    enable      = 1'b0;
    buf0_addr   = BUF0;
    buf1_addr   = BUF1;
    wb.wb_ack_i = 1'b0;
`ifdef VIDEO_IN_STORE_ERR_EN
    wb.wb_err_i = 1'b0;
`endif
    nRST        = 1'b0;
    drive_fifo();
    @(negedge clk);
    #1;
    test_reset();
    test_single_burst();
    test_level_threshold();
    test_wait_states();
    test_frame_wrap();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
`ifdef VIDEO_IN_STORE_ERR_EN
    test_error();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
